// File: rtl/csr_access_seq.sv
// CSR access sequencer: one CSR instruction at a time through READ, WRITE, RESP.
// Optional feature macro: CSR_ACCESS_SEQ_SKIP_ZERO_WRITE_EN (no write for RS/RC with zero rs1 index/zimm).
module csr_access_seq #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            priv_mode,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [CSR_ADDR_W-1:0] req_csr_addr,
    input  logic [4:0]            req_rs1_idx,
    input  logic [XLEN-1:0]       req_rs1_value,
    input  logic [4:0]            req_rd,
    output logic                  csr_read_en,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    input  logic [XLEN-1:0]       csr_read_value,
    input  logic                  csr_illegal,
    output logic                  csr_write_en,
    output logic [XLEN-1:0]       csr_write_value,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [4:0]            resp_rd,
    output logic [XLEN-1:0]       resp_value,
    output logic                  resp_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0]            funct3_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [4:0]            rs1_idx_q;
    logic [4:0]            rd_q;
    logic [XLEN-1:0]       src_q;
    logic [XLEN-1:0]       old_q;
    logic                  illegal_q;
    logic [XLEN-1:0]       resp_value_q;
    logic                  resp_illegal_q;

    logic                  read_suppressed;
    logic                  write_requested;
    logic                  ro_violation;
    logic                  read_illegal;
    logic                  write_fire;
    logic                  final_illegal;
    logic [XLEN-1:0]       new_value;

    // CSRRW with rd=x0 must not cause a read side effect
    assign read_suppressed = (funct3_q[1:0] == 2'b01) && (rd_q == 5'd0);

`ifdef CSR_ACCESS_SEQ_SKIP_ZERO_WRITE_EN
    assign write_requested = !(funct3_q[1] && (rs1_idx_q == 5'd0));
`else
    assign write_requested = 1'b1;
`endif

    assign ro_violation  = write_requested && (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
    assign read_illegal  = (funct3_q[1:0] == 2'b00)
                         || (!read_suppressed && csr_illegal)
                         || (addr_q[9:8] > priv_mode);
    assign write_fire    = write_requested && !illegal_q && !ro_violation;
    // A nonexistent CSR reported during the write still faults, but the strobe is not withdrawn
    assign final_illegal = illegal_q || ro_violation || (write_fire && csr_illegal);

    always_comb begin
        new_value = '0;
        case (funct3_q[1:0])
            2'b01:   new_value = src_q;
            2'b10:   new_value = old_q | src_q;
            2'b11:   new_value = old_q & ~src_q;
            default: new_value = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        csr_read_en     = 1'b0;
        csr_write_en    = 1'b0;
        csr_write_value = '0;
        resp_valid      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                csr_read_en = !read_suppressed;
                state_next  = WRITE;
            end
            WRITE: begin
                csr_write_en    = write_fire;
                csr_write_value = new_value;
                state_next      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Instruction latch, read capture and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            funct3_q       <= '0;
            addr_q         <= '0;
            rs1_idx_q      <= '0;
            rd_q           <= '0;
            src_q          <= '0;
            old_q          <= '0;
            illegal_q      <= 1'b0;
            resp_value_q   <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_q    <= req_csr_addr;
                        rs1_idx_q <= req_rs1_idx;
                        rd_q      <= req_rd;
                        src_q     <= req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx}
                                                   : req_rs1_value;
                    end
                end
                READ: begin
                    old_q     <= read_suppressed ? '0 : csr_read_value;
                    illegal_q <= read_illegal;
                end
                WRITE: begin
                    resp_illegal_q <= final_illegal;
                    resp_value_q   <= final_illegal ? '0 : old_q;
                end
                default: ;
            endcase
        end
    end

    assign csr_addr     = addr_q;
    assign resp_rd      = rd_q;
    assign resp_value   = resp_value_q;
    assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_csr_access_seq.sv
// Self-checking bench for csr_access_seq: directed plan steps plus randomized instructions
// against a behavioural CSR-file and instruction model.
module tb_csr_access_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  priv_mode;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_value;
    logic [4:0]  req_rd;
    logic        csr_read_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_read_value;
    logic        csr_illegal;
    logic        csr_write_en;
    logic [31:0] csr_write_value;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_value;
    logic        resp_illegal;

    logic [31:0] csr_mem [4096];
    int          pass_checks = 0;
    int          total_checks = 0;

    csr_access_seq #(.XLEN(32), .CSR_ADDR_W(12)) dut (
        .clock(clock), .reset(reset), .priv_mode(priv_mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx),
        .req_rs1_value(req_rs1_value), .req_rd(req_rd),
        .csr_read_en(csr_read_en), .csr_addr(csr_addr),
        .csr_read_value(csr_read_value), .csr_illegal(csr_illegal),
        .csr_write_en(csr_write_en), .csr_write_value(csr_write_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_value(resp_value), .resp_illegal(resp_illegal)
    );

    always #5 clock = ~clock;

    // CSR file environment: combinational read, addresses ending in 0xEE do not exist
    assign csr_read_value = csr_mem[csr_addr];
    assign csr_illegal    = (csr_addr[7:0] == 8'hEE);

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) pass_checks++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    // Drives one instruction from a negedge and checks every cycle up to the response handshake
    task automatic apply_stimulus(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                                  input logic [31:0] val, input logic [4:0] rd, input logic [1:0] pm,
                                  input int stall);
        logic [1:0]  op;
        logic [31:0] src, old_val, new_val, exp_value;
        logic        nonexist, priv_fail, read_done, write_req, ro_fail, illegal, exp_write;
        op        = f3[1:0];
        src       = f3[2] ? {27'd0, idx} : val;
        nonexist  = (addr[7:0] == 8'hEE);
        priv_fail = (addr[9:8] > pm);
        read_done = !(op == 2'b01 && rd == 5'd0);
`ifdef CSR_ACCESS_SEQ_SKIP_ZERO_WRITE_EN
        write_req = !((op == 2'b10 || op == 2'b11) && idx == 5'd0);
`else
        write_req = 1'b1;
`endif
        ro_fail   = write_req && (addr[11:10] == 2'b11);
        illegal   = (op == 2'b00) || nonexist || priv_fail || ro_fail;
        exp_write = write_req && (op != 2'b00) && !priv_fail && !ro_fail && !(nonexist && read_done);
        old_val   = read_done ? csr_mem[addr] : 32'd0;
        new_val   = (op == 2'b01) ? src : (op == 2'b10) ? (old_val | src) : (old_val & ~src);
        exp_value = illegal ? 32'd0 : old_val;

        check_output("req_ready_idle", {31'd0, req_ready}, 32'd1);
        priv_mode = pm; req_valid = 1'b1; req_funct3 = f3; req_csr_addr = addr;
        req_rs1_idx = idx; req_rs1_value = val; req_rd = rd;
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0; req_rs1_idx = 5'($urandom); req_rs1_value = $urandom;
        req_rd = 5'($urandom); req_csr_addr = 12'($urandom); req_funct3 = 3'($urandom);
        check_output("read_en", {31'd0, csr_read_en}, {31'd0, read_done});
        check_output("read_addr", {20'd0, csr_addr}, {20'd0, addr});
        check_output("req_ready_busy", {31'd0, req_ready}, 32'd0);
        check_output("write_en_in_read", {31'd0, csr_write_en}, 32'd0);
        @(posedge clock); @(negedge clock);
        check_output("write_en", {31'd0, csr_write_en}, {31'd0, exp_write});
        check_output("resp_valid_early", {31'd0, resp_valid}, 32'd0);
        if (exp_write) begin
            check_output("write_value", csr_write_value, new_val);
            csr_mem[addr] = new_val;
        end
        @(posedge clock); @(negedge clock);
        for (int s = 0; s <= stall; s++) begin
            resp_ready = (s == stall);
            check_output("resp_valid", {31'd0, resp_valid}, 32'd1);
            check_output("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
            check_output("resp_value", resp_value, exp_value);
            check_output("resp_illegal", {31'd0, resp_illegal}, {31'd0, illegal});
            check_output("strobes_in_resp", {30'd0, csr_read_en, csr_write_en}, 32'd0);
            check_output("req_ready_resp", {31'd0, req_ready}, 32'd0);
            @(posedge clock); @(negedge clock);
        end
        resp_ready = 1'b0;
        check_output("resp_valid_after", {31'd0, resp_valid}, 32'd0);
    endtask

    logic [11:0] addr_list [13] = '{12'h340, 12'h300, 12'h305, 12'h100, 12'h141, 12'h000, 12'h040,
                                    12'hC00, 12'hC02, 12'hF11, 12'h7EE, 12'h3EE, 12'h5C0};
    logic [1:0]  priv_list [3] = '{2'd0, 2'd1, 2'd3};

    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] = $urandom;
        reset = 1'b1; priv_mode = 2'd3; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0;
        req_rs1_idx = '0; req_rs1_value = '0; req_rd = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_resp_value", resp_value, 32'd0);
        check_output("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
        check_output("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        check_output("rst_strobes", {30'd0, csr_read_en, csr_write_en}, 32'd0);
        check_output("rst_write_value", csr_write_value, 32'd0);
        check_output("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        reset = 1'b0;

        $display("[TB] directed steps");
        csr_mem[12'h340] = 32'h1234_5678;
        apply_stimulus(3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF, 5'd5, 2'd3, 0);
        check_output("csrrw_result", csr_mem[12'h340], 32'hDEAD_BEEF);
        csr_mem[12'h340] = 32'h0000_0010;
        apply_stimulus(3'b110, 12'h340, 5'd3, 32'h0, 5'd1, 2'd3, 0);
        apply_stimulus(3'b111, 12'h340, 5'd1, 32'h0, 5'd1, 2'd3, 0);
        check_output("csrrci_result", csr_mem[12'h340], 32'h0000_0012);
        apply_stimulus(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd2, 2'd3, 0);
        apply_stimulus(3'b001, 12'h300, 5'd4, 32'h55AA_55AA, 5'd6, 2'd0, 0);
        apply_stimulus(3'b000, 12'h340, 5'd4, 32'h1, 5'd6, 2'd3, 0);
        apply_stimulus(3'b001, 12'h340, 5'd9, 32'hCAFE_F00D, 5'd0, 2'd3, 0);
        apply_stimulus(3'b011, 12'h340, 5'd9, 32'h0000_00F0, 5'd8, 2'd3, 5);
        apply_stimulus(3'b010, 12'h340, 5'd9, 32'h0F00_0000, 5'd9, 2'd3, 0);

        // Reset arriving while the write strobe is active
        priv_mode = 2'd3; req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
        req_rs1_idx = 5'd3; req_rs1_value = 32'hA5A5_A5A5; req_rd = 5'd5;
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        check_output("midrst_write_en_before", {31'd0, csr_write_en}, 32'd1);
        csr_mem[12'h340] = 32'hA5A5_A5A5;
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check_output("midrst_write_en", {31'd0, csr_write_en}, 32'd0);
        check_output("midrst_read_en", {31'd0, csr_read_en}, 32'd0);
        check_output("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        apply_stimulus(3'b010, 12'h340, 5'd0, 32'h0, 5'd4, 2'd3, 0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 60; n++) begin
            logic [4:0] idx, rd;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            apply_stimulus(3'($urandom_range(0, 7)), addr_list[$urandom_range(0, 12)], idx,
                           $urandom, rd, priv_list[$urandom_range(0, 2)], $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/csr_access_seq.md
# csr_access_seq

Multi-cycle CSR access sequencer between decode/issue and the CSR file. Accepts one decoded CSR instruction (CSRRW/CSRRS/CSRRC and immediate forms) per valid/ready handshake. It performs the architectural read, computes the read-modify-write value, checks privilege and read-only rules, and issues the write. It then returns the old CSR value (or an illegal-instruction flag) to writeback over a second valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, data width of CSR values and register operands
- CSR_ADDR_W, 12, CSR address width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- priv_mode  in  2  current privilege level (0=U, 1=S, 3=M)
- req_valid  in  1  decoded CSR instruction present
- req_ready  out  1  sequencer can accept a request
- req_funct3  in  3  bit2: immediate source; bits1:0: 01 RW, 10 RS, 11 RC
- req_csr_addr  in  CSR_ADDR_W  target CSR
- req_rs1_idx  in  5  rs1 index, or zimm when funct3[2]=1
- req_rs1_value  in  XLEN  rs1 register value
- req_rd  in  5  destination register index
- csr_read_en  out  1  read strobe to CSR file
- csr_addr  out  CSR_ADDR_W  address to CSR file
- csr_read_value  in  XLEN  combinational read data from CSR file
- csr_illegal  in  1  CSR file reports nonexistent CSR (valid while csr_read_en or csr_write_en is high)
- csr_write_en  out  1  write strobe to CSR file
- csr_write_value  out  XLEN  write data
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_rd  out  5  destination register index
- resp_value  out  XLEN  old CSR value (0 if illegal)
- resp_illegal  out  1  raise illegal-instruction exception

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch funct3, addr, rd, and src. src = funct3[2] ? zero-extended rs1_idx : rs1_value. Then go to READ.
- READ:
  - csr_addr=latched addr.
  - csr_read_en=1, except for RW with rd=0, where no read side effect is allowed.
  - Capture csr_read_value into old; old=0 when the read is suppressed.
  - Illegal if any of: funct3[1:0]==00, csr_illegal, or addr[9:8] > priv_mode.
  - Go to WRITE.
- WRITE: new value:
  - RW: new=src
  - RS: new=old|src
  - RC: new=old&~src
- Write is requested except for RS/RC with zero source (rs1_idx=0 or zimm=0, by index, not by value), per the macro in Configuration.
- Write to read-only space (addr[11:10]==11) when a write is requested → illegal.
- csr_write_en=1 for exactly one cycle only if the write is requested and the instruction is not illegal. csr_illegal sampled this cycle also flags illegal; the write is not retracted.
- Go to RESP.
- RESP: resp_valid=1 and resp_rd/resp_value/resp_illegal stable until resp_ready. On resp_valid&resp_ready go to IDLE. resp_value=0 when illegal.
- Only one instruction in flight; req_ready=0 outside IDLE.
- Reset:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_value=0, resp_illegal=0, resp_rd=0.
  - csr_read_en=0, csr_write_en=0, csr_write_value=0, csr_addr=0.
- Reset asserted mid-operation: no read/write strobe in the cycle after the reset edge; in-flight instruction discarded.

## Timing
- Handshake at edge N → READ strobe during cycle N+1 → WRITE strobe during N+2 → resp_valid from N+3.
- Latency is fixed at 3 cycles regardless of skipped read/write or illegality.
- resp_valid held across resp_ready=0 stall cycles with outputs unchanged.
- Back-to-back throughput: a new request is accepted the cycle after the RESP handshake (4 cycles/instruction minimum).
- csr_read_value is sampled at the end of the READ cycle; the CSR file must present it combinationally.
- Strobes are registered (driven from state); no combinational path from req_* to csr_* outputs.

## Configuration
- CSR_ACCESS_SEQ_SKIP_ZERO_WRITE_EN defined: RS/RC with zero source index/zimm issue no write. Read-only CSRs are then legal for these forms (csrr pseudo-op works on counters).
- Not defined: every legal RW/RS/RC issues a write, even when the value is unchanged. Any access to addr[11:10]==11 is illegal.

## Test plan
- CSRRW x5, 0x340, rs1=0xDEADBEEF, CSR holds 0x12345678, M-mode → write 0xDEADBEEF at N+2; resp_value=0x12345678, resp_rd=5 at N+3.
- CSRRSI x1, 0x340, zimm=0x3, CSR=0x10 → write 0x13; resp_value=0x10. CSRRCI same CSR with zimm=0x1 → write 0x12.
- CSRRS x2, 0xC00 (cycle), rs1 idx 0, macro defined → no csr_write_en, resp_illegal=0. Macro undefined → resp_illegal=1, resp_value=0, no write.
- CSRRW to 0x300 from U-mode (priv_mode=0) → no csr_write_en, resp_illegal=1; also funct3=000 → illegal.
- Hold resp_ready=0 for 5 cycles → resp_* stable, req_ready=0, no extra strobes; then handshake → next request accepted the following cycle.
- Assert reset during WRITE state → csr_write_en=0 the next cycle, resp_valid=0, req_ready=1.
